// File: rtl/bypass_scoreboard.sv
// Operand-bypass and hazard tracker: a shadow pipeline of in-flight destinations and results
// from EX to WB that answers ID-stage operand reads and drives the register-file write port.
module bypass_scoreboard #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 3,
    parameter int RPORTS = 2,
    parameter int AW     = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     adv,
    input  logic                     issue_valid,
    input  logic [AW-1:0]            issue_rd,
    input  logic [STAGES-1:0]        res_set,
    input  logic [STAGES*WIDTH-1:0]  res_data,
    input  logic [STAGES-1:0]        flush,
    input  logic [RPORTS*AW-1:0]     rs,
    input  logic [RPORTS-1:0]        rs_used,
    input  logic [RPORTS*WIDTH-1:0]  rf_data,
    output logic [RPORTS*WIDTH-1:0]  fwd_data,
    output logic [RPORTS-1:0]        fwd_hit,
    output logic                     stall,
    output logic                     wb_valid,
    output logic [AW-1:0]            wb_rd,
    output logic [WIDTH-1:0]         wb_data
);

    localparam int LAST = STAGES - 1;

    logic [STAGES-1:0] ent_valid;
    logic [STAGES-1:0] ent_ready;
    logic [AW-1:0]     ent_rd   [STAGES];
    logic [WIDTH-1:0]  ent_data [STAGES];

    logic [STAGES-1:0] cap_ready;
    logic [WIDTH-1:0]  cap_data [STAGES];
    logic [RPORTS-1:0] pending;
    logic              found;

    // Each entry as it looks once this cycle's result capture is folded in.
    always_comb begin
        for (int s = 0; s < STAGES; s++) begin
            cap_ready[s] = ent_ready[s] | (ent_valid[s] & res_set[s]);
            cap_data[s]  = (ent_valid[s] && res_set[s]) ? res_data[s*WIDTH +: WIDTH] : ent_data[s];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int s = 0; s < STAGES; s++) begin
                ent_valid[s] <= 1'b0;
                ent_ready[s] <= 1'b0;
                ent_rd[s]    <= '0;
                ent_data[s]  <= '0;
            end
        end else if (adv) begin
            // Register 0 never produces a hazard, so it enters as a bubble.
            ent_valid[0] <= issue_valid && (issue_rd != '0);
            ent_ready[0] <= 1'b0;
            ent_rd[0]    <= issue_valid ? issue_rd : '0;
            ent_data[0]  <= '0;
            for (int s = 1; s < STAGES; s++) begin
                if (ent_valid[s-1] && !flush[s-1]) begin
                    ent_valid[s] <= 1'b1;
                    ent_ready[s] <= cap_ready[s-1];
                    ent_rd[s]    <= ent_rd[s-1];
                    ent_data[s]  <= cap_data[s-1];
                end else begin
                    ent_valid[s] <= 1'b0;
                    ent_ready[s] <= 1'b0;
                    ent_rd[s]    <= '0;
                    ent_data[s]  <= '0;
                end
            end
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (flush[s] || !ent_valid[s]) begin
                    ent_valid[s] <= 1'b0;
                    ent_ready[s] <= 1'b0;
                    ent_rd[s]    <= '0;
                    ent_data[s]  <= '0;
                end else begin
                    ent_ready[s] <= cap_ready[s];
                    ent_data[s]  <= cap_data[s];
                end
            end
        end
    end

    // Youngest matching entry wins; an unready match without a result this cycle is pending.
    always_comb begin
        fwd_data = rf_data;
        fwd_hit  = '0;
        pending  = '0;
        stall    = 1'b0;
        found    = 1'b0;
        for (int p = 0; p < RPORTS; p++) begin
            found = 1'b0;
            for (int s = 0; s < STAGES; s++) begin
                if (!found && ent_valid[s] && (rs[p*AW +: AW] != '0) && (ent_rd[s] == rs[p*AW +: AW])) begin
                    found      = 1'b1;
                    fwd_hit[p] = 1'b1;
                    if (ent_ready[s]) begin
                        fwd_data[p*WIDTH +: WIDTH] = ent_data[s];
                    end else if (res_set[s]) begin
                        fwd_data[p*WIDTH +: WIDTH] = res_data[s*WIDTH +: WIDTH];
                    end else begin
                        pending[p] = 1'b1;
                    end
                end
            end
            stall = stall | (rs_used[p] & pending[p]);
        end
        if (!reset) begin
            fwd_data = rf_data;
            fwd_hit  = '0;
            stall    = 1'b0;
        end
    end

    always_comb begin
        wb_valid = reset && adv && ent_valid[LAST] && cap_ready[LAST];
        wb_rd    = wb_valid ? ent_rd[LAST] : '0;
        wb_data  = wb_valid ? cap_data[LAST] : '0;
    end

    // An entry leaving WB must have its result by then, otherwise the write is lost.
    wb_unready_commit: assert property (@(posedge clk) disable iff (!reset)
        !(adv && ent_valid[LAST] && !cap_ready[LAST]));

endmodule

// File: tb/tb_bypass_scoreboard.sv
// Scoreboard bench for bypass_scoreboard: the driver pushes predictions from an instruction-level
// model of the EX..WB pipeline, and a separate monitor pops and compares them each cycle.
module tb_bypass_scoreboard;

    typedef struct packed {
        logic             rst_n;
        logic             adv;
        logic             iv;
        logic [4:0]       ird;
        logic [2:0]       rset;
        logic [2:0][31:0] rdata;
        logic [2:0]       flush;
        logic [1:0][4:0]  rs;
        logic [1:0]       used;
        logic [1:0][31:0] rf;
    } stim_t;

    typedef struct packed {
        logic [1:0][31:0] fwd;
        logic [1:0]       hit;
        logic             stall;
        logic             wbv;
        logic             chk_wb;
        logic [4:0]       wbrd;
        logic [31:0]      wbd;
    } exp_t;

    typedef struct packed {
        logic        live;
        logic [4:0]  rd;
        logic        done;
        logic [31:0] val;
    } instr_t;

    logic        clk;
    logic        reset;
    logic        adv;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [2:0]  res_set;
    logic [95:0] res_data;
    logic [2:0]  flush;
    logic [9:0]  rs;
    logic [1:0]  rs_used;
    logic [63:0] rf_data;
    logic [63:0] fwd_data;
    logic [1:0]  fwd_hit;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int     total = 0;
    int     bad   = 0;
    exp_t   exp_q[$];
    instr_t pipe[3];
    stim_t  st;

    bypass_scoreboard #(.WIDTH(32), .STAGES(3), .RPORTS(2), .AW(5)) dut (
        .clk(clk), .reset(reset), .adv(adv), .issue_valid(issue_valid), .issue_rd(issue_rd),
        .res_set(res_set), .res_data(res_data), .flush(flush), .rs(rs), .rs_used(rs_used),
        .rf_data(rf_data), .fwd_data(fwd_data), .fwd_hit(fwd_hit), .stall(stall),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: pipe[k] is the instruction k stages past ID; the first live match by age wins.
    function automatic exp_t predict(input stim_t s);
        exp_t e;
        e = '0;
        for (int p = 0; p < 2; p++) e.fwd[p] = s.rf[p];
        if (!s.rst_n) begin
            e.chk_wb = 1'b1;
            return e;
        end
        for (int p = 0; p < 2; p++) begin
            if (s.rs[p] != 5'd0) begin
                for (int k = 0; k < 3; k++) begin
                    if (pipe[k].live && pipe[k].rd == s.rs[p]) begin
                        e.hit[p] = 1'b1;
                        if (pipe[k].done) e.fwd[p] = pipe[k].val;
                        else if (s.rset[k]) e.fwd[p] = s.rdata[k];
                        else if (s.used[p]) e.stall = 1'b1;
                        break;
                    end
                end
            end
        end
        if (s.adv && pipe[2].live && (pipe[2].done || s.rset[2])) begin
            e.wbv    = 1'b1;
            e.chk_wb = 1'b1;
            e.wbrd   = pipe[2].rd;
            e.wbd    = s.rset[2] ? s.rdata[2] : pipe[2].val;
        end
        return e;
    endfunction

    task automatic update_model(input stim_t s);
        if (!s.rst_n) begin
            for (int k = 0; k < 3; k++) pipe[k] = '0;
            return;
        end
        for (int k = 0; k < 3; k++) begin
            if (pipe[k].live && s.rset[k]) begin
                pipe[k].done = 1'b1;
                pipe[k].val  = s.rdata[k];
            end
            if (s.flush[k]) pipe[k] = '0;
        end
        if (s.adv) begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = '0;
            if (s.iv && s.ird != 5'd0) begin
                pipe[0].live = 1'b1;
                pipe[0].rd   = s.ird;
            end
        end
    endtask

    function automatic stim_t base();
        stim_t s;
        s       = '0;
        s.rst_n = 1'b1;
        s.rf[0] = 32'($urandom);
        s.rf[1] = 32'($urandom);
        return s;
    endfunction

    // Drives one cycle of inputs, never letting an unready instruction leave WB.
    task automatic apply_stimulus(input stim_t s_in);
        stim_t s;
        s = s_in;
        if (s.rst_n && s.adv && pipe[2].live && !pipe[2].done && !s.rset[2]) s.rset[2] = 1'b1;
        @(negedge clk);
        reset       = s.rst_n;
        adv         = s.adv;
        issue_valid = s.iv;
        issue_rd    = s.ird;
        res_set     = s.rset;
        res_data    = s.rdata;
        flush       = s.flush;
        rs          = s.rs;
        rs_used     = s.used;
        rf_data     = s.rf;
        exp_q.push_back(predict(s));
        update_model(s);
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_output(input exp_t e);
        for (int p = 0; p < 2; p++) begin
            cmp($sformatf("fwd_data%0d", p), fwd_data[p*32 +: 32], e.fwd[p]);
            cmp($sformatf("fwd_hit%0d", p), 32'(fwd_hit[p]), 32'(e.hit[p]));
        end
        cmp("stall", 32'(stall), 32'(e.stall));
        cmp("wb_valid", 32'(wb_valid), 32'(e.wbv));
        if (e.chk_wb) begin
            cmp("wb_rd", 32'(wb_rd), 32'(e.wbrd));
            cmp("wb_data", wb_data, e.wbd);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_output(e);
            end
        end
    end

    initial begin : driver
        for (int k = 0; k < 3; k++) pipe[k] = '0;
        reset = 1'b0; adv = 1'b0; issue_valid = 1'b0; issue_rd = '0; res_set = '0;
        res_data = '0; flush = '0; rs = '0; rs_used = '0; rf_data = '0;

        st = base(); st.rst_n = 1'b0;
        apply_stimulus(st);
        apply_stimulus(st);

        // Load three entries, then reset with matching reads and issue activity.
        for (int i = 1; i <= 3; i++) begin
            st = base(); st.adv = 1'b1; st.iv = 1'b1; st.ird = 5'(i);
            st.rset = 3'b001; st.rdata[0] = 32'(i * 16);
            apply_stimulus(st);
        end
        for (int i = 0; i < 2; i++) begin
            st = base(); st.rst_n = 1'b0; st.adv = 1'b1; st.iv = 1'b1; st.ird = 5'd2;
            st.rs[0] = 5'd2; st.rs[1] = 5'd3; st.used = 2'b11; st.rset = 3'b011;
            apply_stimulus(st);
        end
        st = base(); st.rs[0] = 5'd2; st.used = 2'b01; st.adv = 1'b1;
        apply_stimulus(st);

        // Back-to-back ALU forwarding, same-cycle and stored.
        st = base(); st.adv = 1'b1; st.iv = 1'b1; st.ird = 5'd8;
        apply_stimulus(st);
        st = base(); st.rset = 3'b001; st.rdata[0] = 32'h0000_1234; st.rs[0] = 5'd8;
        st.used = 2'b01; st.adv = 1'b1; st.iv = 1'b1; st.ird = 5'd3;
        apply_stimulus(st);
        st = base(); st.rs[0] = 5'd8; st.used = 2'b01;
        apply_stimulus(st);

        // Load-use: stall, bubble, then the late result clears the stall in the same cycle.
        st = base(); st.adv = 1'b1; st.iv = 1'b1; st.ird = 5'd9;
        apply_stimulus(st);
        st = base(); st.rs[1] = 5'd9; st.used = 2'b10; st.adv = 1'b1;
        apply_stimulus(st);
        st = base(); st.rs[1] = 5'd9; st.used = 2'b10; st.rset = 3'b010; st.rdata[1] = 32'hDEAD_BEEF;
        apply_stimulus(st);
        for (int i = 0; i < 3; i++) begin
            st = base(); st.adv = 1'b1; st.rset = 3'b111; st.rdata[2] = 32'(32'hA0 + i);
            apply_stimulus(st);
        end

        // Same rd in stages 0 and 2: younger value forwards, older one commits.
        st = base(); st.adv = 1'b1; st.iv = 1'b1; st.ird = 5'd5;
        apply_stimulus(st);
        st = base(); st.adv = 1'b1; st.iv = 1'b1; st.ird = 5'd6; st.rset = 3'b001; st.rdata[0] = 32'h1;
        apply_stimulus(st);
        st = base(); st.adv = 1'b1; st.iv = 1'b1; st.ird = 5'd5;
        apply_stimulus(st);
        st = base(); st.rset = 3'b011; st.rdata[0] = 32'h2; st.rdata[1] = 32'h66; st.rs[0] = 5'd5; st.used = 2'b01;
        apply_stimulus(st);
        st = base(); st.adv = 1'b1; st.rs[0] = 5'd5; st.used = 2'b01;
        apply_stimulus(st);
        for (int i = 0; i < 3; i++) begin
            st = base(); st.adv = 1'b1;
            apply_stimulus(st);
        end

        // Register 0 is never tracked.
        st = base(); st.adv = 1'b1; st.iv = 1'b1; st.ird = 5'd0;
        apply_stimulus(st);
        st = base(); st.adv = 1'b1; st.rset = 3'b001; st.rdata[0] = 32'h55; st.used = 2'b11;
        apply_stimulus(st);
        for (int i = 0; i < 3; i++) begin
            st = base(); st.adv = 1'b1;
            apply_stimulus(st);
        end

        // Flush the two youngest on advance, then hold with probes.
        for (int i = 1; i <= 3; i++) begin
            st = base(); st.adv = 1'b1; st.iv = 1'b1; st.ird = 5'(i); st.rset = 3'b001;
            st.rdata[0] = 32'(32'h100 + i);
            apply_stimulus(st);
        end
        st = base(); st.rset = 3'b001; st.rdata[0] = 32'h103;
        apply_stimulus(st);
        st = base(); st.adv = 1'b1; st.iv = 1'b1; st.ird = 5'd4; st.flush = 3'b011;
        st.rs[0] = 5'd2; st.rs[1] = 5'd3; st.used = 2'b11;
        apply_stimulus(st);
        st = base(); st.adv = 1'b1; st.iv = 1'b1; st.ird = 5'd7; st.rset = 3'b001; st.rdata[0] = 32'h104;
        st.rs[0] = 5'd4; st.rs[1] = 5'd2; st.used = 2'b11;
        apply_stimulus(st);
        st = base(); st.adv = 1'b1; st.rset = 3'b001; st.rdata[0] = 32'h107;
        apply_stimulus(st);
        for (int i = 0; i < 4; i++) begin
            st = base(); st.iv = 1'b1; st.ird = 5'd9; st.rs[0] = 5'd4; st.rs[1] = 5'd7; st.used = 2'b11;
            apply_stimulus(st);
        end

        // Randomized traffic over a small register range so matches are frequent.
        for (int i = 0; i < 400; i++) begin
            st = base();
            st.rst_n = ($urandom_range(0, 49) != 0);
            st.adv   = ($urandom_range(0, 3) != 0);
            st.iv    = 1'($urandom_range(0, 1));
            st.ird   = 5'($urandom_range(0, 7));
            st.rset  = 3'($urandom);
            for (int k = 0; k < 3; k++) st.rdata[k] = 32'($urandom);
            st.flush = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b000;
            if (st.adv) st.flush[2] = 1'b0;
            st.rs[0] = 5'($urandom_range(0, 7));
            st.rs[1] = 5'($urandom_range(0, 7));
            st.used  = 2'($urandom);
            apply_stimulus(st);
        end

        st = base();
        apply_stimulus(st);
        @(negedge clk);
        #3;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        #3;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bypass_scoreboard.md
# bypass_scoreboard

Parametrised operand-bypass and hazard-tracking unit for the pipelined MIPS core. It replaces the fixed per-operand forwarding selectors with a shadow pipeline of in-flight destination registers and results, covering stages EX through WB. It answers every source-operand read from the ID stage with the youngest available value, or raises a stall. It also drives the register-file write port from the oldest stage.

## Interface
- WIDTH, 32, data width
- STAGES, 3, tracked stages after ID (index 0 = EX, STAGES-1 = WB); minimum 2
- RPORTS, 2, number of ID-stage source read ports
- AW, 5, register address width; register 0 is hardwired zero
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-low; overrides all other inputs
- adv  in  1  pipeline advances this edge
- issue_valid  in  1  ID instruction enters EX on this advance (0 = bubble)
- issue_rd  in  AW  destination of issuing instruction
- res_set  in  STAGES  bit s: instruction now in stage s produces its result this cycle
- res_data  in  STAGES*WIDTH  result for stage s, slice [s*WIDTH +: WIDTH]
- flush  in  STAGES  bit s: discard entry in stage s at this edge
- rs  in  RPORTS*AW  source register per port
- rs_used  in  RPORTS  port p actually consumes its operand
- rf_data  in  RPORTS*WIDTH  register-file read data per port
- fwd_data  out  RPORTS*WIDTH  resolved operand per port
- fwd_hit  out  RPORTS  operand came from a tracked entry, not rf_data
- stall  out  1  some used operand is pending; ID must not issue
- wb_valid  out  1  register-file write enable
- wb_rd  out  AW  register-file write address
- wb_data  out  WIDTH  register-file write data

## Operation
- Each stage s holds an entry with fields valid, rd, ready, data.
- Reset: all entries are invalid, with rd, ready and data cleared. While the reset input is low, stall=0, fwd_hit=0, fwd_data=rf_data, wb_valid=0, wb_rd=0 and wb_data=0.
- Capture: if res_set[s] is high and entry s is valid, its data becomes res_data[s] and ready becomes 1. This happens regardless of adv.
  - If ready is already 1, a later res_set overwrites the data.
  - res_set on an invalid entry is ignored.
- Advance (adv=1): entry s+1 takes entry s, including any capture made this cycle. Entry 0 is loaded as follows:
  - issue_valid=1 and issue_rd≠0: valid=1, rd=issue_rd, ready=0.
  - otherwise: a bubble.
- Hold (adv=0): entries keep position. issue_valid is ignored. Capture still applies.
- Flush: flush[s]=1 drops the entry that occupies stage s before the edge.
  - On advance, that entry does not reach s+1.
  - On hold, it becomes invalid in place.
  - Flush beats res_set for the same stage. Stage 0 is loaded normally on advance even when flush[0]=1.
- Lookup for port p, combinational: scan s=0..STAGES-1 and take the first valid entry whose rd equals rs[p].
  - Match with ready=1: fwd_data=entry data, fwd_hit=1.
  - Match, not ready, res_set[s]=1: fwd_data=res_data[s], fwd_hit=1.
  - Match, not ready, no res_set: fwd_data=rf_data[p], fwd_hit=1, and the port is pending.
  - No match, or rs[p]=0: fwd_data=rf_data[p], fwd_hit=0.
- stall = OR over p of (rs_used[p] AND port p pending).
  - The stall response is adv=1 with issue_valid=0, which inserts a bubble into EX.
  - Holding is also legal.
- Commit: wb_valid = adv AND entry[STAGES-1].valid AND (ready OR res_set[STAGES-1]).
  - wb_rd is the entry's rd. wb_data is its stored data, or res_data when it captures in that same cycle.
  - An entry must not reach the last stage unready with no res_set. Verification asserts this; the entry is dropped silently.

## Timing
- Lookup, stall and commit outputs are combinational from registered entries plus current inputs. There is no added cycle.
- Latency: a result set in stage s is forwardable in the same cycle (through the res_set path), and from the stored entry in every following cycle.
- A WB-stage match forwards the value being written that cycle, so there is no register-file write/read hazard.
- An instruction issued at edge n sits in stage k after n+k advances and commits on advance n+STAGES.
- Two entries with the same rd: the lower stage index, i.e. the younger instruction, always wins.
- Reset asserted mid-operation empties the whole tracker at that edge. No commit is issued in that cycle.

## Test plan
- Reset: hold reset low 2 cycles with entries loaded → after the edge, wb_valid=0, stall=0, fwd_hit=0, fwd_data0=rf_data0.
- ALU back-to-back: issue rd=8; while in EX assert res_set[0] with 0x00001234; next ID cycle sets rs0=8 → fwd_data0=0x00001234, fwd_hit0=1, stall=0.
- Load-use: issue rd=9 with no EX result; rs1=9, rs_used1=1 → stall=1. Advance with a bubble, then assert res_set[1]=0xDEADBEEF → stall=0 and fwd_data1=0xDEADBEEF in the same cycle.
- Priority: rd=5 ready in stage 2 (0x1) and in stage 0 (0x2) → fwd_data=0x2. One advance later, wb_valid=1, wb_rd=5, wb_data=0x1.
- Zero register: issue rd=0 with res_set → entry stays invalid; rs=0 gives fwd_data=rf_data and fwd_hit=0; 3 advances later, wb_valid=0.
- Flush and hold: three ready entries, flush=3'b011 with adv=1 → only the old stage-2 entry commits, the next 2 cycles have no commits, and new issues are unaffected. With adv=0 for 4 cycles, wb_valid=0 throughout and the entries are unchanged.
